systolic_mm_engine: RTL and testbench

Parametrised output-stationary systolic matrix-multiply engine. It computes C[ROWS x COLS] = A[ROWS x K] * B[K x COLS] for a runtime K.
- Skews the streamed operands internally.
- Runs a start/busy/done job FSM.
- Unloads results one row per beat over a valid/ready stream.
- Sits between the NPU operand buffers and the result writeback path. It generalises the fixed 4x4 array with fixed 2*SIZE timing.

---
 rtl/npu_sa_pkg.sv | 27 ++
 rtl/sa_mac_pe.sv | 43 ++++
 rtl/systolic_mm_engine.sv | 187 ++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_sa_pkg.sv
// Shared types, default sizes and the product sign-extension helper for the
// systolic matrix-multiply engine.
package npu_sa_pkg;

  localparam int SA_ROWS_DEF   = 4;
  localparam int SA_COLS_DEF   = 4;
  localparam int SA_DATA_W_DEF = 8;
  localparam int SA_ACC_W_DEF  = 32;
  localparam int SA_MAX_K_DEF  = 256;
  localparam int SA_EXT_W      = 128;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    FLUSH,
    UNLOAD
  } sa_state_e;

  // Sign-extend the low w bits of p to SA_EXT_W bits.
  function automatic logic signed [SA_EXT_W-1:0] sext_prod(input logic [SA_EXT_W-1:0] p,
                                                            input int unsigned w);
    logic signed [SA_EXT_W-1:0] t;
    t = $signed(p << (SA_EXT_W - w));
    return t >>> (SA_EXT_W - w);
  endfunction

endpackage

// File: rtl/sa_mac_pe.sv
// Output-stationary MAC cell: forwards a east and b south through registers
// and accumulates a*b every cycle; clear_i zeroes the accumulator.
module sa_mac_pe
  import npu_sa_pkg::*;
#(
  parameter int DATA_W = SA_DATA_W_DEF,
  parameter int ACC_W  = SA_ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] a_o,
  output logic signed [DATA_W-1:0] b_o,
  output logic signed [ACC_W-1:0]  acc_o
);

  logic signed [DATA_W-1:0]   a_q, b_q;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic signed [2*DATA_W-1:0] prod;

  assign prod  = a_i * b_i;
  assign acc_d = clear_i ? '0
               : acc_q + ACC_W'(sext_prod(SA_EXT_W'($unsigned(prod)), 2 * DATA_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// Output-stationary systolic engine computing C = A*B for a runtime K.
// Build option: define SYSTOLIC_RELU_EN to clamp unloaded values at zero.
//
// state  | meaning
// IDLE   | waiting for start; start clears accumulators and captures K
// FEED   | accepting K operand beats; bubbles inject zeros
// FLUSH  | ROWS+COLS-1 zero cycles draining the skewed wavefront
// UNLOAD | one result row per out_valid/out_ready handshake
module systolic_mm_engine
  import npu_sa_pkg::*;
#(
  parameter int  ROWS   = SA_ROWS_DEF,
  parameter int  COLS   = SA_COLS_DEF,
  parameter int  DATA_W = SA_DATA_W_DEF,
  parameter int  ACC_W  = SA_ACC_W_DEF,
  parameter int  MAX_K  = SA_MAX_K_DEF,
  localparam int KW     = $clog2(MAX_K + 1),
  localparam int RW     = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  output logic                   busy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ROWS*DATA_W-1:0] a_col,
  input  logic [COLS*DATA_W-1:0] b_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [RW-1:0]          out_row,
  output logic [COLS*ACC_W-1:0]  out_data,
  output logic                   done
);

  localparam int FW = (ROWS + COLS > 2) ? $clog2(ROWS + COLS) : 1;

  sa_state_e     state_q, state_d;
  logic [KW-1:0] k_q, k_d, beat_q, beat_d, k_cap;
  logic [FW-1:0] flush_q, flush_d;
  logic [RW-1:0] row_q, row_d;
  logic          clear_acc, accept;

  logic signed [DATA_W-1:0] a_h [ROWS][COLS+1];
  logic signed [DATA_W-1:0] b_v [ROWS+1][COLS];
  logic signed [ACC_W-1:0]  acc [ROWS][COLS];

  assign accept = in_valid && (state_q == FEED);
  assign k_cap  = (k_len > KW'(MAX_K)) ? KW'(MAX_K) : k_len;

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    beat_d    = beat_q;
    flush_d   = flush_q;
    row_d     = row_q;
    clear_acc = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear_acc = 1'b1;
          k_d       = k_cap;
          beat_d    = '0;
          state_d   = (k_cap == '0) ? UNLOAD : FEED;
        end
      end
      FEED: begin
        if (accept) begin
          beat_d = beat_q + KW'(1);
          if (beat_q + KW'(1) == k_q) begin
            flush_d = '0;
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        flush_d = flush_q + FW'(1);
        if (flush_q == FW'(ROWS + COLS - 2)) begin
          flush_d = '0;
          state_d = UNLOAD;
        end
      end
      UNLOAD: begin
        if (out_ready) begin
          if (row_q == RW'(ROWS - 1)) begin
            row_d   = '0;
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      flush_q <= flush_d;
      row_q   <= row_d;
    end
  end

  // Row r of A is delayed r cycles so it meets column c of B in PE(r,c).
  for (genvar r = 0; r < ROWS; r++) begin : g_askew
    logic signed [DATA_W-1:0] a_in;
    assign a_in = accept ? $signed(a_col[r*DATA_W +: DATA_W]) : '0;
    if (r == 0) begin : g_direct
      assign a_h[r][0] = a_in;
    end else begin : g_line
      logic signed [DATA_W-1:0] line_q [r];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < r; i++) line_q[i] <= '0;
        end else begin
          line_q[0] <= a_in;
          for (int i = 1; i < r; i++) line_q[i] <= line_q[i-1];
        end
      end
      assign a_h[r][0] = line_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_bskew
    logic signed [DATA_W-1:0] b_in;
    assign b_in = accept ? $signed(b_row[c*DATA_W +: DATA_W]) : '0;
    if (c == 0) begin : g_direct
      assign b_v[0][c] = b_in;
    end else begin : g_line
      logic signed [DATA_W-1:0] line_q [c];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < c; i++) line_q[i] <= '0;
        end else begin
          line_q[0] <= b_in;
          for (int i = 1; i < c; i++) line_q[i] <= line_q[i-1];
        end
      end
      assign b_v[0][c] = line_q[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear_acc),
        .a_i     (a_h[r][c]),
        .b_i     (b_v[r][c]),
        .a_o     (a_h[r][c+1]),
        .b_o     (b_v[r+1][c]),
        .acc_o   (acc[r][c])
      );
    end
  end

  always_comb begin
    out_data = '0;
    if (state_q == UNLOAD) begin
      for (int c = 0; c < COLS; c++) begin
`ifdef SYSTOLIC_RELU_EN
        out_data[c*ACC_W +: ACC_W] = (acc[row_q][c] < 0) ? '0 : acc[row_q][c];
`else
        out_data[c*ACC_W +: ACC_W] = acc[row_q][c];
`endif
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == FEED);
  assign out_valid = (state_q == UNLOAD);
  assign out_row   = row_q;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Self-checking bench for systolic_mm_engine: default 4x4/32-bit instance plus
// a 16-bit accumulator instance sharing the same stimulus for wrap checks.
module tb_systolic_mm_engine;

  localparam int ROWS = 4, COLS = 4, DATA_W = 8, ACC_W = 32, MAX_K = 256;
  localparam int KW = 9, RW = 2, MAXKT = 16;

  logic                   clk = 1'b0;
  logic                   rst_n, start, in_valid, out_ready;
  logic [KW-1:0]          k_len;
  logic [ROWS*DATA_W-1:0] a_col;
  logic [COLS*DATA_W-1:0] b_row;
  logic                   busy, in_ready, out_valid, done;
  logic [RW-1:0]          out_row;
  logic [COLS*ACC_W-1:0]  out_data;
  logic                   busy16, in_ready16, out_valid16, done16;
  logic [RW-1:0]          out_row16;
  logic [COLS*16-1:0]     out_data16;

  systolic_mm_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_K(MAX_K)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_data(out_data), .done(done));

  systolic_mm_engine #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(16), .MAX_K(MAX_K)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .busy(busy16),
    .in_valid(in_valid), .in_ready(in_ready16), .a_col(a_col), .b_row(b_row),
    .out_valid(out_valid16), .out_ready(out_ready), .out_row(out_row16),
    .out_data(out_data16), .done(done16));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  int A [ROWS][MAXKT];
  int B [MAXKT][COLS];

  logic [COLS*ACC_W-1:0] got   [ROWS];
  logic [COLS*16-1:0]    got16 [ROWS];
  int row_seq[$];
  int done_cnt, done_cyc, done_row, first_valid_cyc, last_acc_cyc, start_cyc;
  int stalled_cnt, stall_bad;
  bit timeout, ready_after_start;

  // C[r][c] from the matrix definition, wrapped to w bits, optional ReLU.
  function automatic longint model_elem(int r, int c, int k, int w);
    longint s = 0;
    longint full = longint'(1) << w;
    for (int kk = 0; kk < k; kk++) s += longint'(A[r][kk]) * longint'(B[kk][c]);
    s = s & (full - 1);
    if (s >= (full >> 1)) s -= full;
`ifdef SYSTOLIC_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  function automatic logic [COLS*ACC_W-1:0] model_row(int r, int k);
    logic [COLS*ACC_W-1:0] v = '0;
    for (int c = 0; c < COLS; c++) v[c*ACC_W +: ACC_W] = ACC_W'(model_elem(r, c, k, ACC_W));
    return v;
  endfunction

  function automatic logic [COLS*16-1:0] model_row16(int r, int k);
    logic [COLS*16-1:0] v = '0;
    for (int c = 0; c < COLS; c++) v[c*16 +: 16] = 16'(model_elem(r, c, k, 16));
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(int k);
    for (int kk = 0; kk < k; kk++) begin
      for (int r = 0; r < ROWS; r++) A[r][kk] = $urandom_range(255) - 128;
      for (int c = 0; c < COLS; c++) B[kk][c] = $urandom_range(255) - 128;
    end
  endtask

  task automatic fill_const(int k, int av, int bv);
    for (int kk = 0; kk < k; kk++) begin
      for (int r = 0; r < ROWS; r++) A[r][kk] = av;
      for (int c = 0; c < COLS; c++) B[kk][c] = bv;
    end
  endtask

  // Starts a job and streams k beats; bubbles carry random garbage.
  task automatic drive_job(int k, bit gaps, bit start_hold);
    int  i = 0, budget = 0;
    bit  tog = 1'b1, acc_now;
    start = 1'b1;
    k_len = KW'(k);
    start_cyc = cyc;
    step();
    ready_after_start = in_ready;
    start = start_hold;
    while (i < k && budget < 1000) begin
      in_valid = gaps ? tog : 1'b1;
      tog = ~tog;
      if (start_hold) k_len = KW'($urandom_range(1, 12));
      for (int r = 0; r < ROWS; r++)
        a_col[r*DATA_W +: DATA_W] = in_valid ? DATA_W'(A[r][i]) : DATA_W'($urandom);
      for (int c = 0; c < COLS; c++)
        b_row[c*DATA_W +: DATA_W] = in_valid ? DATA_W'(B[i][c]) : DATA_W'($urandom);
      acc_now = in_valid && in_ready;
      step();
      if (acc_now) begin
        i++;
        last_acc_cyc = cyc;
      end
      budget++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (i < k) timeout = 1'b1;
  endtask

  // Handshakes all rows out, optionally stalling one row for stall_n cycles.
  task automatic collect(int k, int stall_row, int stall_n);
    int  budget = 0;
    bit  finished = 1'b0;
    row_seq.delete();
    done_cnt = 0; done_row = -1; stalled_cnt = 0; stall_bad = 0;
    first_valid_cyc = -1;
    while (!out_valid && budget < 300) begin
      step();
      budget++;
    end
    if (!out_valid) timeout = 1'b1;
    first_valid_cyc = cyc;
    while (!finished && budget < 300) begin
      out_ready = !(int'(out_row) == stall_row && stalled_cnt < stall_n);
      #1;
      if (!out_ready) begin
        stalled_cnt++;
        if (out_valid !== 1'b1 || int'(out_row) != stall_row || out_data !== model_row(stall_row, k))
          stall_bad++;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        done_row = out_row;
      end
      if (out_valid && out_ready) begin
        got[out_row]   = out_data;
        got16[out_row] = out_data16;
        row_seq.push_back(int'(out_row));
        if (out_row == RW'(ROWS - 1)) finished = 1'b1;
      end
      step();
      budget++;
    end
    out_ready = 1'b0;
    if (!finished) timeout = 1'b1;
    repeat (3) begin
      if (done === 1'b1) done_cnt++;
      step();
    end
  endtask

  task automatic check_timeout(string name);
    checks++;
    if (timeout) begin
      errors++;
      $display("FAIL %s timeout: got=expired bound exp=completion", name);
    end
    timeout = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({busy, in_ready, out_valid, done, out_row, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0", {busy, in_ready, out_valid, done, out_row, out_data});
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_identity();
    logic [COLS*ACC_W-1:0] exp_v;
    int seq, exp_seq;
    for (int kk = 0; kk < 4; kk++) begin
      for (int r = 0; r < ROWS; r++) A[r][kk] = (r == kk) ? 1 : 0;
      for (int c = 0; c < COLS; c++) B[kk][c] = kk * 4 + c + 1;
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_in_ready got=%b exp=0", in_ready);
    end
    drive_job(4, 1'b0, 1'b0);
    checks++;
    if (ready_after_start !== 1'b1) begin
      errors++;
      $display("FAIL feed_in_ready got=%b exp=1", ready_after_start);
    end
    collect(4, -1, 0);
    check_timeout("identity");
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) exp_v[c*ACC_W +: ACC_W] = ACC_W'(r * 4 + c + 1);
      checks++;
      if (got[r] !== exp_v) begin
        errors++;
        $display("FAIL identity_row%0d got=%h exp=%h", r, got[r], exp_v);
      end
    end
    seq = row_seq.size(); exp_seq = ROWS;
    foreach (row_seq[i]) begin seq = seq * 8 + row_seq[i]; exp_seq = exp_seq * 8 + i; end
    checks++;
    if (seq != exp_seq) begin
      errors++;
      $display("FAIL identity_row_order got=%0h exp=%0h", seq, exp_seq);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL identity_done_pulses got=%0d exp=1", done_cnt);
    end
    checks++;
    if (first_valid_cyc - last_acc_cyc != ROWS + COLS - 1) begin
      errors++;
      $display("FAIL flush_latency got=%0d exp=%0d", first_valid_cyc - last_acc_cyc, ROWS + COLS - 1);
    end
    checks++;
    if (done_cyc - first_valid_cyc != ROWS - 1) begin
      errors++;
      $display("FAIL done_latency got=%0d exp=%0d", done_cyc - first_valid_cyc, ROWS - 1);
    end
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++;
      $display("FAIL idle_after_job got=%b exp=00", {busy, out_valid});
    end
  endtask

  task automatic test_k1_sign();
    logic [COLS*ACC_W-1:0] exp_v;
    fill_const(1, 2, -3);
    drive_job(1, 1'b0, 1'b0);
    collect(1, -1, 0);
    check_timeout("k1_sign");
    for (int c = 0; c < COLS; c++)
`ifdef SYSTOLIC_RELU_EN
      exp_v[c*ACC_W +: ACC_W] = '0;
`else
      exp_v[c*ACC_W +: ACC_W] = ACC_W'(-6);
`endif
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (got[r] !== exp_v) begin
        errors++;
        $display("FAIL k1_sign_row%0d got=%h exp=%h", r, got[r], exp_v);
      end
    end
  endtask

  task automatic test_random();
    int k;
    repeat (4) begin
      k = $urandom_range(1, 8);
      fill_random(k);
      drive_job(k, 1'b0, 1'b0);
      collect(k, -1, 0);
      check_timeout("random");
      for (int r = 0; r < ROWS; r++) begin
        checks++;
        if (got[r] !== model_row(r, k)) begin
          errors++;
          $display("FAIL random_k%0d_row%0d got=%h exp=%h", k, r, got[r], model_row(r, k));
        end
      end
    end
  endtask

  task automatic test_bubbles();
    fill_random(8);
    for (int pass = 0; pass < 2; pass++) begin
      drive_job(8, pass == 1, 1'b0);
      collect(8, -1, 0);
      check_timeout("bubbles");
      for (int r = 0; r < ROWS; r++) begin
        checks++;
        if (got[r] !== model_row(r, 8)) begin
          errors++;
          $display("FAIL bubbles_gap%0d_row%0d got=%h exp=%h", pass, r, got[r], model_row(r, 8));
        end
      end
    end
  endtask

  task automatic test_stall();
    int seq, exp_seq;
    fill_random(4);
    drive_job(4, 1'b0, 1'b0);
    collect(4, 1, 5);
    check_timeout("stall");
    checks++;
    if (stall_bad != 0 || stalled_cnt != 5) begin
      errors++;
      $display("FAIL stall_hold got=bad%0d/stalled%0d exp=bad0/stalled5", stall_bad, stalled_cnt);
    end
    seq = row_seq.size(); exp_seq = ROWS;
    foreach (row_seq[i]) begin seq = seq * 8 + row_seq[i]; exp_seq = exp_seq * 8 + i; end
    checks++;
    if (seq != exp_seq) begin
      errors++;
      $display("FAIL stall_row_order got=%0h exp=%0h", seq, exp_seq);
    end
    checks++;
    if (done_cnt != 1 || done_row != ROWS - 1) begin
      errors++;
      $display("FAIL stall_done got=cnt%0d/row%0d exp=cnt1/row%0d", done_cnt, done_row, ROWS - 1);
    end
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (got[r] !== model_row(r, 4)) begin
        errors++;
        $display("FAIL stall_row%0d got=%h exp=%h", r, got[r], model_row(r, 4));
      end
    end
  endtask

  task automatic test_start_in_feed();
    fill_random(5);
    drive_job(5, 1'b1, 1'b1);
    collect(5, -1, 0);
    check_timeout("start_in_feed");
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (got[r] !== model_row(r, 5)) begin
        errors++;
        $display("FAIL start_in_feed_row%0d got=%h exp=%h", r, got[r], model_row(r, 5));
      end
    end
  endtask

  task automatic test_k0();
    drive_job(0, 1'b0, 1'b0);
    checks++;
    if (ready_after_start !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL k0_direct_unload got=ready%b/valid%b exp=ready0/valid1", ready_after_start, out_valid);
    end
    collect(0, -1, 0);
    check_timeout("k0");
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (got[r] !== '0) begin
        errors++;
        $display("FAIL k0_row%0d got=%h exp=0", r, got[r]);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL k0_done_pulses got=%0d exp=1", done_cnt);
    end
  endtask

  task automatic test_reset_mid_flush();
    logic [COLS*ACC_W-1:0] exp_v;
    fill_random(4);
    drive_job(4, 1'b0, 1'b0);
    step();
    step();
    checks++;
    if ({busy, in_ready, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL in_flush got=%b exp=100", {busy, in_ready, out_valid});
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, in_ready, out_valid, done, out_row, out_data} !== '0) begin
      errors++;
      $display("FAIL reset_mid_flush got=%h exp=0", {busy, in_ready, out_valid, done, out_row, out_data});
    end
    step();
    rst_n = 1'b1;
    step();
    fill_const(2, 1, 1);
    drive_job(2, 1'b0, 1'b0);
    collect(2, -1, 0);
    check_timeout("after_reset");
    for (int c = 0; c < COLS; c++) exp_v[c*ACC_W +: ACC_W] = ACC_W'(2);
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (got[r] !== exp_v) begin
        errors++;
        $display("FAIL after_reset_row%0d got=%h exp=%h", r, got[r], exp_v);
      end
    end
  endtask

  task automatic test_overflow();
    fill_const(3, -128, -128);
    drive_job(3, 1'b0, 1'b0);
    collect(3, -1, 0);
    check_timeout("overflow");
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (got16[r] !== model_row16(r, 3) || got[r] !== model_row(r, 3)) begin
        errors++;
        $display("FAIL overflow_row%0d got=%h/%h exp=%h/%h", r, got16[r], got[r],
                 model_row16(r, 3), model_row(r, 3));
      end
    end
    checks++;
    if (model_row16(0, 3) !== {COLS{16'(model_elem(0, 0, 3, 16))}} || got16[0][15:0] !==
`ifdef SYSTOLIC_RELU_EN
        16'h0000) begin
`else
        16'hC000) begin
`endif
      errors++;
      $display("FAIL overflow_wrap_value got=%h", got16[0][15:0]);
    end
  endtask

  task automatic test_clamp();
    int beats = 0, budget = 0;
    logic [COLS*ACC_W-1:0] exp_v;
    start = 1'b1;
    k_len = KW'(300);
    step();
    start = 1'b0;
    in_valid = 1'b1;
    for (int r = 0; r < ROWS; r++) a_col[r*DATA_W +: DATA_W] = 8'd1;
    for (int c = 0; c < COLS; c++) b_row[c*DATA_W +: DATA_W] = 8'd1;
    while (in_ready && budget < 400) begin
      step();
      beats++;
      budget++;
    end
    in_valid = 1'b0;
    checks++;
    if (beats != MAX_K) begin
      errors++;
      $display("FAIL clamp_beats got=%0d exp=%0d", beats, MAX_K);
    end
    collect(MAX_K, -1, 0);
    check_timeout("clamp");
    for (int c = 0; c < COLS; c++) exp_v[c*ACC_W +: ACC_W] = ACC_W'(MAX_K);
    checks++;
    if (got[ROWS-1] !== exp_v) begin
      errors++;
      $display("FAIL clamp_result got=%h exp=%h", got[ROWS-1], exp_v);
    end
  endtask

  initial begin
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    k_len = '0; a_col = '0; b_row = '0; timeout = 1'b0;
    test_reset();
    test_identity();
    test_k1_sign();
    test_random();
    test_bubbles();
    test_stall();
    test_start_in_feed();
    test_k0();
    test_reset_mid_flush();
    test_overflow();
    test_clamp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
